// File: rtl/jtframe_inputs_map.sv
// Input conditioner between the MiSTer HPS joystick/PS2 feed and a game core.
// Merges PS/2 keys into player 1 and adds per-player autofire on button 0.
// Stretches coin pulses and toggles pause. All game_* outputs are registered
// and active-low.
module jtframe_inputs_map #(
    parameter int PLAYERS     = 2,
    parameter int BUTTONS     = 2,
    parameter int AF_FRAMES   = 2,
    parameter int COIN_CYCLES = 48000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [10:0]                   ps2_key,
    input  logic [16*PLAYERS-1:0]         joy,
    input  logic                          vs,
    input  logic [PLAYERS-1:0]            autofire_en,
    input  logic                          pause_clr,
    output logic [(4+BUTTONS)*PLAYERS-1:0] game_joy,
    output logic [PLAYERS-1:0]            game_start,
    output logic [PLAYERS-1:0]            game_coin,
    output logic                          game_test,
    output logic                          pause
);
    localparam int W   = 4 + BUTTONS;
    localparam int P2  = (PLAYERS > 1) ? 1 : 0;
    localparam int CW  = $clog2(AF_FRAMES + 1);
    localparam int KW  = $clog2(COIN_CYCLES + 1);
    localparam logic [CW-1:0] AF_LAST   = CW'(AF_FRAMES - 1);
    localparam logic [KW-1:0] COIN_LOAD = KW'(COIN_CYCLES - 1);

    // Key state bit positions; the low four match the joystick direction bits
    localparam logic [3:0] K_RIGHT = 4'd0,  K_LEFT = 4'd1,  K_DOWN  = 4'd2,  K_UP    = 4'd3;
    localparam logic [3:0] K_B0A   = 4'd4,  K_B0B  = 4'd5,  K_B1    = 4'd6,  K_B2    = 4'd7;
    localparam logic [3:0] K_B3    = 4'd8,  K_B4   = 4'd9,  K_B5    = 4'd10, K_ST1   = 4'd11;
    localparam logic [3:0] K_ST2   = 4'd12, K_COIN = 4'd13, K_PAUSE = 4'd14, K_TEST  = 4'd15;

    logic        old_tog_q, valid_q;
    logic [15:0] keys_q, keys_d;
    logic [3:0]  kidx;
    logic        khit;
    logic        vs_q, vs_fall;
    logic        test_q, pause_q, pause_d, pause_prev_q, pause_any;
    logic [PLAYERS-1:0]        pause_req;
    logic [PLAYERS-1:0][15:0]  kreq;

    assign vs_fall   = vs_q & ~vs;
    assign pause_any = |pause_req;
    assign game_test = test_q;
    assign pause     = pause_q;

    // Scan code decode; an event is a toggle of bit 10 once the first sample is taken
    always_comb begin
        kidx = K_RIGHT;
        khit = 1'b1;
        case (ps2_key[7:0])
            8'h74: kidx = K_RIGHT;
            8'h6B: kidx = K_LEFT;
            8'h72: kidx = K_DOWN;
            8'h75: kidx = K_UP;
            8'h14: kidx = K_B0A;
            8'h11: kidx = K_B0B;
            8'h29: kidx = K_B1;
            8'h12: kidx = K_B2;
            8'h1A: kidx = K_B3;
            8'h22: kidx = K_B4;
            8'h21: kidx = K_B5;
            8'h05: kidx = K_ST1;
            8'h06: kidx = K_ST2;
            8'h04: kidx = K_COIN;
            8'h0C: kidx = K_PAUSE;
            8'h03: kidx = K_TEST;
            default: khit = 1'b0;
        endcase
        keys_d = keys_q;
        if (valid_q && (ps2_key[10] != old_tog_q) && khit)
            keys_d[kidx] = ps2_key[9];
    end

    // Keyboard requests laid out like joystick words; only player 1 (and start2) are fed
    always_comb begin
        kreq = '0;
        kreq[0][3:0] = keys_q[3:0];
        kreq[0][4]   = keys_q[K_B0A] | keys_q[K_B0B];
        for (int i = 1; i < BUTTONS; i++)
            kreq[0][4+i] = keys_q[5+i];
        kreq[0][4+BUTTONS] = keys_q[K_ST1];
        kreq[0][5+BUTTONS] = keys_q[K_COIN];
        kreq[0][6+BUTTONS] = keys_q[K_PAUSE];
        if (PLAYERS > 1)
            kreq[P2][4+BUTTONS] = keys_q[K_ST2];
    end

    // Pause toggles on a rising request; clear wins over a simultaneous toggle
    always_comb begin
        pause_d = pause_q;
        if (pause_clr)
            pause_d = 1'b0;
        else if (pause_any && !pause_prev_q)
            pause_d = ~pause_q;
    end

    // Shared registers: PS/2 tracking, key states, frame edge, test and pause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old_tog_q    <= 1'b0;
            valid_q      <= 1'b0;
            keys_q       <= '0;
            vs_q         <= 1'b0;
            test_q       <= 1'b1;
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            old_tog_q    <= ps2_key[10];
            valid_q      <= 1'b1;
            keys_q       <= keys_d;
            vs_q         <= vs;
            test_q       <= ~keys_q[K_TEST];
            pause_q      <= pause_d;
            pause_prev_q <= pause_any;
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
        logic [15:0]        req;
        logic               b0_prev_q, af_phase_q, af_phase_d;
        logic [CW-1:0]      af_cnt_q, af_cnt_d;
        logic               coin_prev_q;
        logic [KW-1:0]      coin_cnt_q, coin_cnt_d;
        logic [BUTTONS-1:0] btn_d;
        logic [W-1:0]       joy_q;
        logic               start_q, coin_q;

        assign req          = kreq[p] | joy[16*p +: 16];
        assign pause_req[p] = req[6+BUTTONS];
        assign game_joy[W*p +: W] = joy_q;
        assign game_start[p]      = start_q;
        assign game_coin[p]       = coin_q;

        // Autofire phase/frame counter and coin stretch counter next state
        always_comb begin
            af_phase_d = af_phase_q;
            af_cnt_d   = af_cnt_q;
            if (req[4] && !b0_prev_q) begin
                af_phase_d = 1'b1;
                af_cnt_d   = '0;
            end else if (req[4] && vs_fall) begin
                if (af_cnt_q == AF_LAST) begin
                    af_phase_d = ~af_phase_q;
                    af_cnt_d   = '0;
                end else begin
                    af_cnt_d = af_cnt_q + 1'b1;
                end
            end
            coin_cnt_d = coin_cnt_q;
            if (coin_cnt_q != '0)
                coin_cnt_d = coin_cnt_q - 1'b1;
            else if (req[5+BUTTONS] && !coin_prev_q)
                coin_cnt_d = COIN_LOAD;
            btn_d = req[4 +: BUTTONS];
            if (autofire_en[p])
                btn_d[0] = req[4] & af_phase_d;
        end

        // Per-player state and active-low output registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                b0_prev_q   <= 1'b0;
                af_phase_q  <= 1'b0;
                af_cnt_q    <= '0;
                coin_prev_q <= 1'b0;
                coin_cnt_q  <= '0;
                joy_q       <= '1;
                start_q     <= 1'b1;
                coin_q      <= 1'b1;
            end else begin
                b0_prev_q   <= req[4];
                af_phase_q  <= af_phase_d;
                af_cnt_q    <= af_cnt_d;
                coin_prev_q <= req[5+BUTTONS];
                coin_cnt_q  <= coin_cnt_d;
                joy_q       <= ~{btn_d, req[3:0]};
                start_q     <= ~req[4+BUTTONS];
                coin_q      <= ~(req[5+BUTTONS] | (coin_cnt_q != '0));
            end
        end
    end
endmodule

// File: doc/jtframe_inputs_map.md
Name: jtframe_inputs_map

Overview:
Multi-player input conditioner between the MiSTer HPS joystick/PS2 feed and a jt*_game core. It merges PS/2 keyboard events for player 1 with per-player joystick words and adds per-player autofire on button 0. It also stretches coin pulses and generates a pause toggle. All outputs are registered and active-low, ready for the game's joystick, start and coin ports.

Parameters:
PLAYERS, 2, number of players, 1..4
BUTTONS, 2, fire buttons per player, 1..6
AF_FRAMES, 2, autofire half-period in frames (VS falling edges), >=1
COIN_CYCLES, 48000, minimum coin low time in clk cycles, >=1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scan code
joy  in  16*PLAYERS  MiSTer joystick words, player p at [16p+15:16p], active-high
vs  in  1  game vertical sync, frame tick on falling edge
autofire_en  in  PLAYERS  per-player autofire enable for button 0
pause_clr  in  1  synchronous force of pause to 0
game_joy  out  (4+BUTTONS)*PLAYERS  per player {buttons, up, down, left, right}, active-low
game_start  out  PLAYERS  active-low
game_coin  out  PLAYERS  active-low
game_test  out  1  active-low
pause  out  1  1 = paused

Behaviour:
- Reset values: game_joy, game_start, game_coin and game_test all 1s. pause=0. All key states 0. Autofire and coin counters 0.
- Joy word layout per player:
  - [0] right, [1] left, [2] down, [3] up
  - [4+i] button i
  - [4+BUTTONS] start, [5+BUTTONS] coin, [6+BUTTONS] pause
- PS/2 decode:
  - Register old_tog and a valid flag. valid=0 in reset; first clk after reset captures old_tog and sets valid, with no event decoded.
  - An event is ps2_key[10] != old_tog while valid=1. The key state is written with ps2_key[9] on that edge.
- Key map (each key is its own state bit; a key map entry ORs into P1 only):
  - 75 up, 72 down, 6B left, 74 right
  - 14 and 11 both drive button0; releasing one does not clear the other
  - 29 button1, 12 button2, 1A button3, 22 button4, 21 button5; a button key is ignored when its index >= BUTTONS
  - 05 start1; 06 start2 (ignored if PLAYERS=1)
  - 04 coin P1, 0C pause request, 03 test
  - Unlisted codes: no effect.
- Request per bit = key state OR joy bit. game_* = ~request, registered.
  - Latency: 1 clk from joy; 2 clk from the ps2 event edge.
- Autofire, per player p, when autofire_en[p]=1:
  - On the rising edge of the button0 request: phase=1 and frame count=0.
  - While held, each VS falling edge increments the count; when count reaches AF_FRAMES-1, phase toggles and count clears.
  - Output button0 = held & phase. Release forces the output inactive at once.
  - autofire_en=0: button0 passes through directly.
- Coin, per player:
  - Rising edge of the coin request loads a counter with COIN_CYCLES-1 and drives game_coin low.
  - Output stays low while counter != 0 or the request is held: low time = max(hold, COIN_CYCLES).
  - A rising edge while the counter is non-zero is ignored (no reload).
- Pause:
  - A rising edge of the OR of all pause requests toggles pause.
  - pause_clr=1 forces pause=0 and has priority over a simultaneous toggle edge.
- Asserting rst mid-pulse or mid-autofire returns everything to the reset values immediately.

Test Plan:
- Reset release with ps2_key[10]=1 held steady -> no key state change. All outputs 1; pause=0.
- Toggle ps2_key[10] with {pressed=1, code=14}, then {1, 11}, then {0, 14} -> game_joy P1 bit4 is 0 two clks after the first event and stays 0 after the 14 release. It goes to 1 after {0, 11}.
- autofire_en[0]=1, AF_FRAMES=2, joy[4] held for 8 VS falling edges -> output pattern pressed 2 frames, released 2 frames, repeated. Pressed from the first clk after the press; released 1 clk after joy[4] drops.
- COIN_CYCLES=10, joy P2 coin pulse for 3 clks -> game_coin[1] low for exactly 10 clks. Re-pulse at clk 5 -> no extension. Hold 20 clks -> low 20 clks.
- Pause requested via key 0C press, then joy P1 pause bit -> pause 0→1→0. pause_clr coincident with a rising request edge -> pause=0.
- PLAYERS=4, BUTTONS=6: drive a distinct bit pattern on each joy word -> game_joy slices match ~pattern per player. Keyboard affects P1 only; key 21 drives P1 button5.
